cordic_phase_gen: RTL and testbench

CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

---
 rtl/cordic_pkg.sv | 43 ++++
 rtl/cordic_lfsr16.sv | 36 +++
 rtl/cordic_phase_gen.sv | 129 ++++++++++++
 tb/tb_cordic_phase_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, state type and helpers for the CORDIC phase generator and stages.
// Angles are signed Q14 radians held in 32-bit words.
package cordic_pkg;

    localparam logic [31:0] PI         = 32'h0000C90F;
    localparam logic [31:0] TWO_PI     = 32'h0001921F;
    localparam logic [31:0] NEG_TWO_PI = 32'hFFFE6DE1;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cordic_state_e;

    // Clamp a signed step to [-TWO_PI, +TWO_PI] so a single wrap correction suffices.
    function automatic logic [31:0] sat_step(input logic [31:0] step);
        logic [31:0] r;
        r = step;
        if ($signed(step) > $signed(TWO_PI)) begin
            r = TWO_PI;
        end else if ($signed(step) < $signed(NEG_TWO_PI)) begin
            r = NEG_TWO_PI;
        end
        return r;
    endfunction

    function automatic logic [31:0] wrap_add(input logic [31:0] acc, input logic [31:0] step);
        logic signed [32:0] s;
        logic signed [32:0] pi_s;
        logic signed [32:0] tp_s;
        pi_s = $signed({1'b0, PI});
        tp_s = $signed({1'b0, TWO_PI});
        s    = $signed({acc[31], acc}) + $signed({step[31], step});
        if (s > pi_s) begin
            s = s - tp_s;
        end else if (s < -pi_s) begin
            s = s + tp_s;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/cordic_lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, used as a 1-LSB phase dither source.
module cordic_lfsr16
    import cordic_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        advance_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        fb;

    always_comb begin
        fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = LFSR_SEED;
        end else if (advance_i) begin
            lfsr_d = {fb, lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase sweep generator feeding a CORDIC: emits count wrapped Q14 angles, one per rate+1 cycles.
// Optional 1-LSB output dither enabled by defining CORDIC_PHASE_DITHER_EN.
module cordic_phase_gen
    import cordic_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] step_in,
    input  logic [15:0] count_in,
    input  logic [7:0]  rate_in,
    output logic        busy,
    output logic        done,
    output logic        valid_out,
    output logic [31:0] theta_out
);

    cordic_state_e state_q, state_d;
    logic [31:0]   step_q,  step_d;
    logic [31:0]   acc_q,   acc_d;
    logic [7:0]    div_q,   div_d;
    logic [7:0]    rate_q,  rate_d;
    logic [15:0]   rem_q,   rem_d;
    logic          valid_q, valid_d;
    logic          done_q,  done_d;
    logic [31:0]   theta_q, theta_d;

    logic emit;
    logic accept;
    logic dither_bit;

`ifdef CORDIC_PHASE_DITHER_EN
    logic [15:0] lfsr_state;

    cordic_lfsr16 u_lfsr (
        .clk_i     (clk),
        .rst_i     (reset),
        .load_i    (accept),
        .advance_i (emit),
        .state_o   (lfsr_state)
    );

    assign dither_bit = lfsr_state[0];
`else
    assign dither_bit = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && start;
    assign emit   = (state_q == ST_RUN) && (div_q == rate_q);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        div_d   = div_q;
        rate_d  = rate_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    step_d  = sat_step(step_in);
                    rem_d   = count_in;
                    rate_d  = rate_in;
                    acc_d   = '0;
                    div_d   = '0;
                    state_d = (count_in != 16'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (emit) begin
                    acc_d = wrap_add(acc_q, step_q);
                    rem_d = rem_q - 16'd1;
                    div_d = '0;
                    if (rem_q == 16'd1) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered: the sample leaves with the pre-update accumulator.
    always_comb begin
        valid_d = emit;
        done_d  = (state_q == ST_DONE);
        theta_d = theta_q;
        if (emit) begin
            theta_d = acc_q + {31'd0, dither_bit};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            acc_q   <= '0;
            div_q   <= '0;
            rate_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            theta_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            rate_q  <= rate_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            theta_q <= theta_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign valid_out = valid_q;
    assign theta_out = theta_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen against a plain-arithmetic sweep model.
module tb_cordic_phase_gen;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] step_in;
    logic [15:0] count_in;
    logic [7:0]  rate_in;
    logic        busy;
    logic        done;
    logic        valid_out;
    logic [31:0] theta_out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] hold_theta = 32'd0;

    localparam longint M_PI  = 51471;
    localparam longint M_2PI = 102943;

    cordic_phase_gen dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .step_in   (step_in),
        .count_in  (count_in),
        .rate_in   (rate_in),
        .busy      (busy),
        .done      (done),
        .valid_out (valid_out),
        .theta_out (theta_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic longint m_wrap(input longint s);
        if (s > M_PI)  return s - M_2PI;
        if (s < -M_PI) return s + M_2PI;
        return s;
    endfunction

    function automatic longint m_clamp(input logic [31:0] st);
        longint v;
        v = longint'($signed(st));
        if (v > M_2PI)  return M_2PI;
        if (v < -M_2PI) return -M_2PI;
        return v;
    endfunction

    // Start a sweep and check every cycle up to stop_j cycles after the accepting edge.
    task automatic run_sweep(input logic [31:0] st, input int unsigned cnt, input int unsigned rt,
                             input string name, input bit hold, input int unsigned stop_j);
        longint      acc;
        longint      stp;
        int unsigned span;
        logic        e_valid, e_busy, e_done;
        logic [31:0] e_theta;
        logic [31:0] tmp;
`ifdef CORDIC_PHASE_DITHER_EN
        logic [15:0] lf;
        lf = 16'hACE1;
`endif
        @(negedge clk);
        start    = 1'b1;
        step_in  = st;
        count_in = 16'(cnt);
        rate_in  = 8'(rt);
        @(posedge clk);
        #1;
        start    = hold;
        step_in  = $urandom;
        count_in = 16'($urandom_range(1, 50));
        rate_in  = 8'($urandom_range(0, 5));
        span = (rt + 1) * cnt;
        stp  = m_clamp(st);
        acc  = 0;
        for (int unsigned j = 0; j <= span + 1 && j <= stop_j; j++) begin
            if (j != 0) @(posedge clk);
            @(negedge clk);
            e_valid = (j > 0) && (j % (rt + 1) == 0) && (j <= span);
            e_busy  = (j <= span);
            e_done  = (j == span + 1);
            if (e_valid) begin
                tmp = acc[31:0];
`ifdef CORDIC_PHASE_DITHER_EN
                tmp = tmp + {31'd0, lf[0]};
                lf  = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
`endif
                hold_theta = tmp;
                acc = m_wrap(acc + stp);
            end
            e_theta = hold_theta;
            n_cmp++;
            if (valid_out !== e_valid) begin
                n_bad++;
                $display("FAIL %s valid j=%0d got %b want %b", name, j, valid_out, e_valid);
            end
            n_cmp++;
            if (busy !== e_busy) begin
                n_bad++;
                $display("FAIL %s busy j=%0d got %b want %b", name, j, busy, e_busy);
            end
            n_cmp++;
            if (done !== e_done) begin
                n_bad++;
                $display("FAIL %s done j=%0d got %b want %b", name, j, done, e_done);
            end
            n_cmp++;
            if (theta_out !== e_theta) begin
                n_bad++;
                $display("FAIL %s theta j=%0d got %h want %h", name, j, theta_out, e_theta);
            end
`ifndef CORDIC_PHASE_DITHER_EN
            if (e_valid) begin
                n_cmp++;
                if ($signed(theta_out) > 32'sd51471 || $signed(theta_out) < -32'sd51471) begin
                    n_bad++;
                    $display("FAIL %s range j=%0d got %h want within +/-0000c90f", name, j, theta_out);
                end
            end
`endif
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        step_in  = '0;
        count_in = '0;
        rate_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, valid_out, theta_out} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset outputs got b%b d%b v%b t%h want all 0", busy, done, valid_out, theta_out);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, valid_out} !== 3'd0) begin
            n_bad++;
            $display("FAIL idle_after_reset got b%b d%b v%b want 000", busy, done, valid_out);
        end
    endtask

    task automatic test_ramp();
        run_sweep(32'h0000_1000, 4, 0, "ramp", 1'b0, 1000);
    endtask

    task automatic test_rate();
        run_sweep(32'h0000_6000, 3, 2, "rate2", 1'b0, 1000);
        run_sweep(32'h0000_6000, 6, 1, "poswrap", 1'b0, 1000);
    endtask

    task automatic test_negative();
        run_sweep(32'hFFFF_A000, 3, 0, "neg", 1'b0, 1000);
        run_sweep(32'hFFFF_A000, 6, 0, "negwrap", 1'b0, 1000);
    endtask

    task automatic test_zero_count();
        run_sweep(32'h0000_1234, 0, 3, "zero_count", 1'b0, 1000);
    endtask

    task automatic test_saturation();
        run_sweep(32'h7FFF_FFFF, 7, 0, "sat_pos", 1'b0, 1000);
        run_sweep(32'h8000_0000, 5, 1, "sat_neg", 1'b0, 1000);
    endtask

    task automatic test_held_start_reset();
        run_sweep(32'h0000_1000, 6, 1, "held_start", 1'b1, 6);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, valid_out, theta_out} !== 35'd0) begin
            n_bad++;
            $display("FAIL async_reset got b%b d%b v%b t%h want all 0", busy, done, valid_out, theta_out);
        end
        hold_theta = 32'd0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, valid_out} !== 3'd0 || theta_out !== 32'd0) begin
                n_bad++;
                $display("FAIL post_abort i=%0d got b%b d%b v%b t%h want 0", i, busy, done, valid_out, theta_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] st;
        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 0) st = $urandom;
            else begin
                st = 32'($urandom_range(0, 32'h0002_0000));
                if ($urandom_range(0, 1) == 1) st = -st;
            end
            run_sweep(st, $urandom_range(0, 7), $urandom_range(0, 3), "random", 1'b0, 1000);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_rate();
        test_negative();
        test_zero_count();
        test_saturation();
        test_held_start_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
